// File: rtl/res_station_n.sv
// Reservation station: DEPTH tagged entries snoop the CDB; the oldest ready entry is offered for dispatch.
// Issue lands at the edge and is dispatchable next cycle; isFull blocks issue, EXEable=0 holds the dispatch outputs.
module res_station_n #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int LABEL_W    = 4,
  parameter int OP_W       = 2,
  parameter int LABEL_BASE = 1
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       WEN,
  input  logic [OP_W-1:0]            opCode,
  input  logic [DATA_W-1:0]          dataIn1,
  input  logic [DATA_W-1:0]          dataIn2,
  input  logic [LABEL_W-1:0]         label1,
  input  logic [LABEL_W-1:0]         label2,
  input  logic                       BCEN,
  input  logic [LABEL_W-1:0]         BClabel,
  input  logic [DATA_W-1:0]          BCdata,
  input  logic                       flush,
  output logic                       isFull,
  output logic [LABEL_W-1:0]         allocLabel,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       EXEable,
  output logic                       OutEn,
  output logic [OP_W-1:0]            opOut,
  output logic [DATA_W-1:0]          dataOut1,
  output logic [DATA_W-1:0]          dataOut2,
  output logic [LABEL_W-1:0]         labelOut
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [DATA_W-1:0]  vj;
    logic [LABEL_W-1:0] qj;
    logic [DATA_W-1:0]  vk;
    logic [LABEL_W-1:0] qk;
  } entry_t;

  logic [DEPTH-1:0] busy;
  entry_t           ent [DEPTH];
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             alloc_ok;
  logic             fire;
  entry_t           new_ent;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) alloc_idx = IDX_W'(i);
  end

  assign isFull     = &busy;
  assign alloc_ok   = WEN && !isFull;
  assign allocLabel = LABEL_W'(LABEL_BASE) + LABEL_W'(alloc_idx);

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + CNT_W'(busy[i]);
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && (ent[i].qj == '0) && (ent[i].qk == '0);
  end

  // An entry wins when no other ready entry is marked older in its age row.
  always_comb begin
    sel_idx = '0;
    OutEn   = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && !(|(ready & age[i]))) begin
        sel_idx = IDX_W'(i);
        OutEn   = 1'b1;
      end
  end

  always_comb begin
    opOut    = '0;
    dataOut1 = '0;
    dataOut2 = '0;
    labelOut = '0;
    if (OutEn) begin
      opOut    = ent[sel_idx].op;
      dataOut1 = ent[sel_idx].vj;
      dataOut2 = ent[sel_idx].vk;
      labelOut = LABEL_W'(LABEL_BASE) + LABEL_W'(sel_idx);
    end
  end

  assign fire = OutEn && EXEable;

  always_comb begin
    new_ent.op = opCode;
    new_ent.vj = dataIn1;
    new_ent.qj = label1;
    new_ent.vk = dataIn2;
    new_ent.qk = label2;
    if (BCEN && (label1 != '0) && (BClabel == label1)) begin
      new_ent.vj = BCdata;
      new_ent.qj = '0;
    end
    if (BCEN && (label2 != '0) && (BClabel == label2)) begin
      new_ent.vk = BCdata;
      new_ent.qk = '0;
    end
  end

  // Allocating entry i clears column i everywhere so stale "older" marks from its previous life vanish.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
        age[i] <= '0;
      end
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && BCEN && (BClabel != '0) && (ent[i].qj == BClabel)) begin
          ent[i].vj <= BCdata;
          ent[i].qj <= '0;
        end
        if (busy[i] && BCEN && (BClabel != '0) && (ent[i].qk == BClabel)) begin
          ent[i].vk <= BCdata;
          ent[i].qk <= '0;
        end
        if (alloc_ok) age[i][alloc_idx] <= 1'b0;
      end
      if (fire) busy[sel_idx] <= 1'b0;
      if (alloc_ok) begin
        busy[alloc_idx] <= 1'b1;
        ent[alloc_idx]  <= new_ent;
        age[alloc_idx]  <= busy;
      end
    end
  end
endmodule

// File: tb/tb_res_station_n.sv
// Bench for res_station_n: directed scenarios plus a randomized run against a timestamp-ordered entry model.
module tb_res_station_n;
  localparam int DEPTH = 4, DATA_W = 32, LABEL_W = 4, OP_W = 2, LABEL_BASE = 1;

  logic              clk = 1'b0;
  logic              nRST;
  logic              WEN, BCEN, flush, EXEable;
  logic [OP_W-1:0]   opCode;
  logic [DATA_W-1:0] dataIn1, dataIn2, BCdata;
  logic [LABEL_W-1:0] label1, label2, BClabel;
  logic              isFull, OutEn;
  logic [LABEL_W-1:0] allocLabel, labelOut;
  logic [2:0]        count;
  logic [OP_W-1:0]   opOut;
  logic [DATA_W-1:0] dataOut1, dataOut2;

  int n_cmp = 0;
  int n_err = 0;

  res_station_n #(.DEPTH(DEPTH), .DATA_W(DATA_W), .LABEL_W(LABEL_W), .OP_W(OP_W), .LABEL_BASE(LABEL_BASE)) dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .opCode(opCode), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .label1(label1), .label2(label2), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .flush(flush),
    .isFull(isFull), .allocLabel(allocLabel), .count(count), .EXEable(EXEable), .OutEn(OutEn),
    .opOut(opOut), .dataOut1(dataOut1), .dataOut2(dataOut2), .labelOut(labelOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WEN = 0; opCode = 0; dataIn1 = 0; dataIn2 = 0; label1 = 0; label2 = 0;
    BCEN = 0; BClabel = 0; BCdata = 0; flush = 0; EXEable = 0;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                       input logic [LABEL_W-1:0] l1, input logic [LABEL_W-1:0] l2);
    WEN = 1; opCode = op; dataIn1 = d1; dataIn2 = d2; label1 = l1; label2 = l2;
  endtask

  task automatic test_reset();
    idle();
    nRST = 0;
    #1;
    n_cmp++; if (OutEn !== 1'b0) begin n_err++; $display("FAIL reset_outen: got %0h expected 0", OutEn); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (isFull !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0h expected 0", isFull); end
    n_cmp++; if (allocLabel !== 4'd1) begin n_err++; $display("FAIL reset_alloc: got %0d expected 1", allocLabel); end
    n_cmp++; if (labelOut !== 4'd0 || dataOut1 !== 0 || dataOut2 !== 0 || opOut !== 0) begin
      n_err++; $display("FAIL reset_outputs: got %0h/%0h/%0h/%0h expected all 0", labelOut, dataOut1, dataOut2, opOut); end
    @(negedge clk);
    nRST = 1;
  endtask

  task automatic test_basic();
    issue(2'd1, 32'd5, 32'd7, 4'd0, 4'd0);
    EXEable = 1;
    tick();
    WEN = 0;
    n_cmp++; if (OutEn !== 1'b1) begin n_err++; $display("FAIL basic_outen: got %0h expected 1", OutEn); end
    n_cmp++; if (labelOut !== 4'd1) begin n_err++; $display("FAIL basic_label: got %0d expected 1", labelOut); end
    n_cmp++; if (dataOut1 !== 32'd5 || dataOut2 !== 32'd7 || opOut !== 2'd1) begin
      n_err++; $display("FAIL basic_data: got %0h/%0h op %0h expected 5/7 op 1", dataOut1, dataOut2, opOut); end
    tick();
    n_cmp++; if (OutEn !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL basic_drain: got outen %0h count %0d expected 0/0", OutEn, count); end
    idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (allocLabel !== 4'(i + 1)) begin n_err++; $display("FAIL fill_alloc: got %0d expected %0d", allocLabel, i + 1); end
      issue(2'(i), 32'(i), 32'(100 + i), 4'd9, 4'd0);
      tick();
    end
    n_cmp++; if (isFull !== 1'b1 || count !== 3'd4 || OutEn !== 1'b0) begin
      n_err++; $display("FAIL fill_full: got full %0h count %0d outen %0h expected 1/4/0", isFull, count, OutEn); end
    tick();
    n_cmp++; if (isFull !== 1'b1 || count !== 3'd4 || OutEn !== 1'b0) begin
      n_err++; $display("FAIL fill_ignored: got full %0h count %0d outen %0h expected 1/4/0", isFull, count, OutEn); end
    idle();
  endtask

  task automatic test_broadcast();
    BCEN = 1; BClabel = 4'd9; BCdata = 32'h1234; EXEable = 1;
    tick();
    BCEN = 0;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (OutEn !== 1'b1 || labelOut !== 4'(i + 1) || dataOut1 !== 32'h1234 || dataOut2 !== 32'(100 + i)) begin
        n_err++; $display("FAIL bcast_dispatch%0d: got outen %0h label %0d data %0h/%0h expected 1/%0d/1234/%0h",
                          i, OutEn, labelOut, dataOut1, dataOut2, i + 1, 100 + i); end
      tick();
    end
    n_cmp++; if (isFull !== 1'b0 || count !== 3'd0) begin
      n_err++; $display("FAIL bcast_empty: got full %0h count %0d expected 0/0", isFull, count); end
    idle();
  endtask

  task automatic test_bypass();
    issue(2'd3, 32'h55, 32'h66, 4'd6, 4'd0);
    BCEN = 1; BClabel = 4'd6; BCdata = 32'hAA;
    tick();
    idle();
    n_cmp++; if (OutEn !== 1'b1 || dataOut1 !== 32'hAA || labelOut !== 4'd1) begin
      n_err++; $display("FAIL bypass: got outen %0h data %0h label %0d expected 1/aa/1", OutEn, dataOut1, labelOut); end
    EXEable = 1;
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL bypass_drain: got %0d expected 0", count); end
    idle();
  endtask

  task automatic test_age();
    issue(2'd1, 32'h11, 32'h0, 4'd7, 4'd0);
    tick();
    issue(2'd2, 32'h22, 32'h0, 4'd0, 4'd0);
    tick();
    WEN = 0;
    n_cmp++; if (OutEn !== 1'b1 || labelOut !== 4'd2) begin
      n_err++; $display("FAIL age_first: got outen %0h label %0d expected 1/2", OutEn, labelOut); end
    EXEable = 1;
    tick();
    EXEable = 0;
    n_cmp++; if (count !== 3'd1 || allocLabel !== 4'd2) begin
      n_err++; $display("FAIL age_freed: got count %0d alloc %0d expected 1/2", count, allocLabel); end
    issue(2'd3, 32'h33, 32'h0, 4'd0, 4'd0);
    tick();
    WEN = 0;
    BCEN = 1; BClabel = 4'd7; BCdata = 32'h77;
    tick();
    BCEN = 0;
    n_cmp++; if (OutEn !== 1'b1 || labelOut !== 4'd1 || dataOut1 !== 32'h77) begin
      n_err++; $display("FAIL age_oldest: got label %0d data %0h expected 1/77", labelOut, dataOut1); end
    EXEable = 1;
    tick();
    n_cmp++; if (OutEn !== 1'b1 || labelOut !== 4'd2 || dataOut1 !== 32'h33) begin
      n_err++; $display("FAIL age_second: got label %0d data %0h expected 2/33", labelOut, dataOut1); end
    tick();
    n_cmp++; if (count !== 3'd0 || OutEn !== 1'b0) begin
      n_err++; $display("FAIL age_drain: got count %0d outen %0h expected 0/0", count, OutEn); end
    idle();
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) begin
      issue(2'd0, 32'(i), 32'(i), 4'd9, 4'd0);
      tick();
    end
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d expected 3", count); end
    flush = 1;
    issue(2'd1, 32'h1, 32'h2, 4'd0, 4'd0);
    tick();
    idle();
    n_cmp++; if (count !== 3'd0 || isFull !== 1'b0 || OutEn !== 1'b0) begin
      n_err++; $display("FAIL flush: got count %0d full %0h outen %0h expected 0/0/0", count, isFull, OutEn); end
    issue(2'd2, 32'h5, 32'h6, 4'd0, 4'd0);
    tick();
    WEN = 0;
    EXEable = 1;
    n_cmp++; if (OutEn !== 1'b1) begin n_err++; $display("FAIL flush_reissue: got %0h expected 1", OutEn); end
    #2;
    nRST = 0;
    #1;
    n_cmp++; if (OutEn !== 1'b0 || labelOut !== 0 || dataOut1 !== 0 || dataOut2 !== 0 || opOut !== 0) begin
      n_err++; $display("FAIL midreset_outputs: got %0h/%0h/%0h/%0h/%0h expected all 0", OutEn, labelOut, dataOut1, dataOut2, opOut); end
    n_cmp++; if (count !== 3'd0 || isFull !== 1'b0 || allocLabel !== 4'd1) begin
      n_err++; $display("FAIL midreset_state: got count %0d full %0h alloc %0d expected 0/0/1", count, isFull, allocLabel); end
    idle();
    @(negedge clk);
    nRST = 1;
  endtask

  // Model: each entry remembers when it was issued; the ready entry with the earliest issue stamp dispatches.
  logic              m_busy [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [DATA_W-1:0] m_vj   [DEPTH];
  logic [DATA_W-1:0] m_vk   [DEPTH];
  logic [LABEL_W-1:0] m_qj  [DEPTH];
  logic [LABEL_W-1:0] m_qk  [DEPTH];
  int                m_stamp[DEPTH];

  function automatic logic [LABEL_W-1:0] pick_label();
    int r;
    r = $urandom_range(0, 5);
    return (r < 3) ? 4'd0 : 4'(r + 2);
  endfunction

  task automatic test_random();
    int stamp = 0;
    nRST = 0;
    idle();
    #1;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    @(negedge clk);
    nRST = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int cnt = 0, free = -1, sel = -1;
      logic [LABEL_W-1:0] e_label;
      logic [DATA_W-1:0]  e_d1, e_d2;
      logic [OP_W-1:0]    e_op;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i]) cnt++;
        else if (free < 0) free = i;
        if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && (sel < 0 || m_stamp[i] < m_stamp[sel])) sel = i;
      end
      e_label = (sel >= 0) ? 4'(LABEL_BASE + sel) : 4'd0;
      e_d1 = (sel >= 0) ? m_vj[sel] : 32'd0;
      e_d2 = (sel >= 0) ? m_vk[sel] : 32'd0;
      e_op = (sel >= 0) ? m_op[sel] : 2'd0;
      n_cmp++; if (count !== 3'(cnt)) begin n_err++; $display("FAIL rnd_count c%0d: got %0d expected %0d", cyc, count, cnt); end
      n_cmp++; if (isFull !== (cnt == DEPTH)) begin n_err++; $display("FAIL rnd_full c%0d: got %0h expected %0h", cyc, isFull, cnt == DEPTH); end
      if (free >= 0) begin
        n_cmp++; if (allocLabel !== 4'(LABEL_BASE + free)) begin
          n_err++; $display("FAIL rnd_alloc c%0d: got %0d expected %0d", cyc, allocLabel, LABEL_BASE + free); end
      end
      n_cmp++; if (OutEn !== (sel >= 0) || labelOut !== e_label) begin
        n_err++; $display("FAIL rnd_select c%0d: got outen %0h label %0d expected %0h/%0d", cyc, OutEn, labelOut, sel >= 0, e_label); end
      n_cmp++; if (dataOut1 !== e_d1 || dataOut2 !== e_d2 || opOut !== e_op) begin
        n_err++; $display("FAIL rnd_data c%0d: got %0h/%0h op %0h expected %0h/%0h op %0h", cyc, dataOut1, dataOut2, opOut, e_d1, e_d2, e_op); end

      WEN = $urandom_range(0, 1); opCode = 2'($urandom); dataIn1 = $urandom; dataIn2 = $urandom;
      label1 = pick_label(); label2 = pick_label();
      BCEN = ($urandom_range(0, 9) < 4);
      BClabel = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(5, 7));
      BCdata = $urandom;
      flush = ($urandom_range(0, 49) == 0);
      EXEable = ($urandom_range(0, 9) < 6);

      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (m_busy[i] && BCEN && BClabel != 0) begin
            if (m_qj[i] == BClabel) begin m_vj[i] = BCdata; m_qj[i] = 0; end
            if (m_qk[i] == BClabel) begin m_vk[i] = BCdata; m_qk[i] = 0; end
          end
        if (sel >= 0 && EXEable) m_busy[sel] = 0;
        if (WEN && free >= 0) begin
          m_busy[free] = 1;
          m_op[free] = opCode;
          m_stamp[free] = stamp++;
          if (label1 != 0 && BCEN && BClabel == label1) begin m_vj[free] = BCdata; m_qj[free] = 0; end
          else begin m_vj[free] = dataIn1; m_qj[free] = label1; end
          if (label2 != 0 && BCEN && BClabel == label2) begin m_vk[free] = BCdata; m_qk[free] = 0; end
          else begin m_vk[free] = dataIn2; m_qk[free] = label2; end
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_broadcast();
    test_bypass();
    test_age();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/res_station_n.md
RES_STATION_N -- requirements
Module: res_station_n

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, operand width.
REQ-003 SHALL have parameter LABEL_W, default 4, tag width; label 0 = "no pending producer".
REQ-004 SHALL have parameter OP_W, default 2, opcode width.
REQ-005 SHALL have parameter LABEL_BASE, default 1, tag of entry 0; entry i tag = LABEL_BASE+i; LABEL_BASE>=1 and LABEL_BASE+DEPTH-1 < 2^LABEL_W.
REQ-006 SHALL have ports: clk  in  1  clock; nRST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: WEN  in  1  issue request; opCode  in  OP_W; dataIn1, dataIn2  in  DATA_W  Vj/Vk; label1, label2  in  LABEL_W  Qj/Qk.
REQ-008 SHALL have ports: BCEN  in  1  CDB valid; BClabel  in  LABEL_W; BCdata  in  DATA_W.
REQ-009 SHALL have ports: flush  in  1  synchronous clear of all entries.
REQ-010 SHALL have ports: isFull  out  1; allocLabel  out  LABEL_W  tag the next accepted issue receives; count  out  $clog2(DEPTH+1)  busy entries.
REQ-011 SHALL have ports: EXEable  in  1  functional unit accepts; OutEn  out  1  dispatch valid; opOut  out  OP_W; dataOut1, dataOut2  out  DATA_W; labelOut  out  LABEL_W  tag of dispatched entry.

Function
REQ-012 Each entry SHALL hold busy, op, Vj, Qj, Vk, Qk and a DEPTH-bit age row.
REQ-013 allocLabel SHALL be LABEL_BASE + lowest free index; isFull SHALL be 1 iff all entries busy (both combinational from registered state).
REQ-014 WEN with isFull=0 SHALL write the allocated entry at the clock edge: busy=1, op, Vj/Qj, Vk/Qk; WEN with isFull=1 SHALL be ignored, no state change.
REQ-015 Issue bypass: if BCEN=1 and labelN!=0 and BClabel==labelN in the issue cycle, entry SHALL store BCdata and Q=0 for that operand.
REQ-016 Snoop: every busy entry with Qj (resp. Qk) !=0 and ==BClabel while BCEN=1 SHALL capture BCdata and clear Qj (resp. Qk) at that edge; BClabel=0 SHALL never match.
REQ-017 Entry ready = busy & Qj==0 & Qk==0, from registered state only; operand captured at edge t SHALL make entry dispatchable no earlier than cycle t+1.
REQ-018 Age: on allocation of entry i, row i SHALL be set to the current busy vector (bit j=1: j older than i); freed entries' bits irrelevant.
REQ-019 Dispatch select SHALL be the oldest ready entry (ready i with no ready j marked older); OutEn = any ready.
REQ-020 opOut/dataOut1/dataOut2/labelOut SHALL be the selected entry's fields when OutEn=1, all zero when OutEn=0.
REQ-021 Handshake: OutEn=1 & EXEable=1 at an edge SHALL clear that entry's busy; OutEn SHALL not depend on EXEable; outputs SHALL hold while EXEable=0.
REQ-022 Entry freed at edge t SHALL not be reallocated at edge t (allocation uses pre-edge busy); simultaneous WEN+dispatch SHALL keep count unchanged.
REQ-023 count SHALL equal popcount(busy); it never exceeds DEPTH nor underflows.
REQ-024 flush=1 SHALL clear all busy at the edge, overriding WEN, snoop and dispatch that cycle.

Reset
REQ-025 nRST=0 SHALL immediately clear all busy, Q and V fields, and age rows; outputs: isFull=0, count=0, allocLabel=LABEL_BASE, OutEn=0, opOut/dataOut1/dataOut2/labelOut=0; reset mid-operation discards all entries.

Verification (DEPTH=4, LABEL_BASE=1, LABEL_W=4)
REQ-026 Reset, WEN op=1, label1=label2=0, data 5/7, EXEable=1 -> next cycle OutEn=1, labelOut=1, dataOut1=5, dataOut2=7; following cycle OutEn=0, count=0.
REQ-027 Four WEN with label1=9 -> allocLabel 1,2,3,4, isFull=1, count=4; fifth WEN ignored, count stays 4, OutEn=0.
REQ-028 Then BCEN=1, BClabel=9, BCdata=0x1234, EXEable=1 held -> next cycle OutEn=1, dataOut1=0x1234, labelOut 1,2,3,4 in consecutive cycles, then isFull=0, count=0.
REQ-029 WEN label1=6 with BCEN=1, BClabel=6, BCdata=0xAA same cycle -> entry ready next cycle, dataOut1=0xAA, Qj never waits.
REQ-030 Entry1 pending on 7, entry2 ready dispatched and reallocated ready; then BCEN label 7 -> both ready, labelOut=1 first, then 2.
REQ-031 flush=1 with WEN=1, count=3 -> next cycle count=0, isFull=0, OutEn=0; nRST low mid-dispatch -> all outputs zero without a clock edge.
